bcd_accum_ctrl: RTL

//  Sequencer for a multi-digit BCD accumulator built around a single-digit BCD adder.
//  - On start, adds operand_b to the internal accumulator one digit per cycle, least

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 21 ++
 rtl/bcd_accum_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state encoding and digit check for the BCD accumulator
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single-digit BCD adder, (a + b + cin) mod 10 with decimal carry
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (sum >= BCD_BASE);
    // For sums 10..19, subtracting 10 equals adding 6 modulo 16.
    s    = sum[3:0] + (cout ? 4'd6 : 4'd0);
  end

endmodule

// File: rtl/bcd_accum_ctrl.sv
// rtl/bcd_accum_ctrl.sv - digit-serial sequencer: acc <= acc + operand_b, LSD first
module bcd_accum_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   operand_b,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   acc
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [1:0]            state;
  logic [IW-1:0]         idx;
  logic                  carry;
  logic [4*DIGITS-1:0]   b_lat;
  logic [3:0]            a_dig;
  logic [3:0]            b_dig;
  logic [3:0]            s_dig;
  logic                  cout;
  logic                  op_ok;
  logic                  last;

  always_comb begin
    op_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(operand_b[4*i +: 4])) op_ok = 1'b0;
    end
  end

  assign a_dig = acc[{idx, 2'b00} +: 4];
  assign b_dig = b_lat[{idx, 2'b00} +: 4];
  assign last  = (idx == IW'(DIGITS - 1));

  bcd_digit_add u_add (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      b_lat    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      invalid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done    <= 1'b0;
      invalid <= 1'b0;
      if (clr) begin
        state    <= ST_IDLE;
        idx      <= '0;
        carry    <= 1'b0;
        acc      <= '0;
        busy     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (op_ok) begin
                b_lat    <= operand_b;
                idx      <= '0;
                carry    <= 1'b0;
                overflow <= 1'b0;
                busy     <= 1'b1;
                state    <= ST_ADD;
              end else begin
                invalid <= 1'b1;
              end
            end
          end
          ST_ADD: begin
            acc[{idx, 2'b00} +: 4] <= s_dig;
            carry <= cout;
            idx   <= idx + 1'b1;
            if (last) begin
              idx      <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              overflow <= cout;
              state    <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
